// File: rtl/time_to_digits_if.sv
// ----------------------------------------------------------------------------
// time_to_digits_if
//   Bundles the signals between second_counter, time_to_digits and
//   display_control.
//
//   Handshake: there is no valid/ready pair. sec_count is a level that the
//   converter samples whenever it is idle and the value differs from the last
//   one it converted. done is a one-cycle pulse that coincides with the
//   digits taking their new value; busy is high from capture until that pulse.
//
//   Signals
//     sec_count  master->slave  binary seconds
//     digit3..0  slave->master  M tens, M ones, S tens, S ones (BCD, 4'hF blank)
//     busy       slave->master  conversion in progress
//     done       slave->master  digits updated this cycle
//     fsm_state  slave->master  debug view of the converter state
//
//   Modports: master (producer of sec_count / consumer of digits), slave
//   (the converter).
// ----------------------------------------------------------------------------
interface time_to_digits_if #(
  parameter int CNT_W = 12
);
  logic [CNT_W-1:0] sec_count;
  logic [3:0]       digit3;
  logic [3:0]       digit2;
  logic [3:0]       digit1;
  logic [3:0]       digit0;
  logic             busy;
  logic             done;
  logic [2:0]       fsm_state;

  modport master (
    output sec_count,
    input  digit3, digit2, digit1, digit0, busy, done, fsm_state
  );

  modport slave (
    input  sec_count,
    output digit3, digit2, digit1, digit0, busy, done, fsm_state
  );
endinterface

// File: rtl/time_to_digits.sv
// ----------------------------------------------------------------------------
// time_to_digits
//   Converts a binary elapsed-second count into four BCD digits MM:SS.
//   Division is done by repeated subtraction: by 60 for minutes, then by 10
//   for the seconds digits and the minutes digits. The four digit outputs
//   change together, only when a conversion completes, so the display never
//   shows a partial result.
//
//   Ports
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    time_to_digits_if.slave (sec_count in; digits, busy, done,
//            fsm_state out)
//
//   Parameters
//     CNT_W    width of sec_count (must match the interface)
//     MAX_SEC  largest convertible value; larger inputs show 99:59
//
//   Build option
//     BLANK_LEAD_ZERO_EN  when defined, digit3 shows 4'hF (blank) whenever
//                         the minutes tens digit is zero.
// ----------------------------------------------------------------------------
module time_to_digits #(
  parameter int CNT_W   = 12,
  parameter int MAX_SEC = 5999
) (
  input  logic              clk,
  input  logic              rst_n,
  time_to_digits_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIV60 = 3'd1,
    SEC10 = 3'd2,
    MIN10 = 3'd3,
    LOAD  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] SIXTY = CNT_W'(60);
  localparam logic [CNT_W-1:0] TEN   = CNT_W'(10);
  // Compare against the clamp limit in 32 bits: MAX_SEC need not fit CNT_W.
  localparam logic [31:0]      MAX_W = MAX_SEC;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] last_val;
  logic [6:0]       min_acc;
  logic [3:0]       s_tens;
  logic [3:0]       s_ones;
  logic [3:0]       m_tens;
  logic [31:0]      sec_wide;
  logic             changed;
  logic [3:0]       d3_load;

  assign sec_wide      = 32'(bus.sec_count);
  assign changed       = (bus.sec_count != last_val);
  assign bus.fsm_state = state;

`ifdef BLANK_LEAD_ZERO_EN
  assign d3_load = (m_tens == 4'd0) ? 4'hF : m_tens;
`else
  assign d3_load = m_tens;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: each arithmetic state stays put while it can still
  // subtract, and leaves on the first cycle its remainder is below the divisor.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (changed) state_nx = DIV60;
      DIV60:   if (rem < SIXTY) state_nx = SEC10;
      SEC10:   if (rem < TEN) state_nx = MIN10;
      MIN10:   if (min_acc < 7'd10) state_nx = LOAD;
      LOAD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem        <= '0;
      last_val   <= '0;
      min_acc    <= '0;
      s_tens     <= '0;
      s_ones     <= '0;
      m_tens     <= '0;
      bus.digit3 <= '0;
      bus.digit2 <= '0;
      bus.digit1 <= '0;
      bus.digit0 <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (changed) begin
            rem      <= (sec_wide > MAX_W) ? CNT_W'(MAX_SEC) : bus.sec_count;
            last_val <= bus.sec_count;
            min_acc  <= '0;
            s_tens   <= '0;
            s_ones   <= '0;
            m_tens   <= '0;
            bus.busy <= 1'b1;
          end
        end
        DIV60: begin
          if (rem >= SIXTY) begin
            rem     <= rem - SIXTY;
            min_acc <= min_acc + 7'd1;
          end
        end
        SEC10: begin
          if (rem >= TEN) begin
            rem    <= rem - TEN;
            s_tens <= s_tens + 4'd1;
          end else begin
            s_ones <= rem[3:0];
          end
        end
        MIN10: begin
          // min_acc is reduced in place; what is left is the minutes ones digit.
          if (min_acc >= 7'd10) begin
            min_acc <= min_acc - 7'd10;
            m_tens  <= m_tens + 4'd1;
          end
        end
        LOAD: begin
          bus.digit3 <= d3_load;
          bus.digit2 <= min_acc[3:0];
          bus.digit1 <= s_tens;
          bus.digit0 <= s_ones;
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_time_to_digits.sv
module tb_time_to_digits;

  localparam int CNT_W   = 12;
  localparam int MAX_SEC = 5999;
  localparam int TIMEOUT = 400;

  logic clk;
  logic rst_n;

  time_to_digits_if #(.CNT_W(CNT_W)) bus ();

  time_to_digits #(.CNT_W(CNT_W), .MAX_SEC(MAX_SEC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] digits_now();
    return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
  endfunction

  function automatic logic [3:0] show_d3(input logic [3:0] t);
`ifdef BLANK_LEAD_ZERO_EN
    return (t == 4'd0) ? 4'hF : t;
`else
    return t;
`endif
  endfunction

  // Reference model: MM:SS by plain division, plus the expected latency.
  task automatic ref_model(input int v, output logic [15:0] d, output int lat);
    int c, m, s;
    c = (v > MAX_SEC) ? MAX_SEC : v;
    m = c / 60;
    s = c % 60;
    d = {show_d3(4'(m / 10)), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    lat = m + (s / 10) + (m / 10) + 4;
  endtask

  // ---------------- driver tasks ----------------
  // Waits (from a negedge) until done is seen; cyc counts negedges waited.
  // Digits must not move before done.
  task automatic wait_done(input string name, output int cyc, output bit ok);
    logic [15:0] pre;
    bit moved;
    pre   = digits_now();
    moved = 1'b0;
    cyc   = 0;
    ok    = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (digits_now() !== pre) moved = 1'b1;
    end
    check({name, " timeout"}, 32'(ok), 32'd1);
    check({name, " no_partial"}, 32'(moved), 32'd0);
  endtask

  // Drives a new value at a negedge and follows it through one conversion.
  task automatic run_conv(input string name, input logic [CNT_W-1:0] val,
                          input logic [15:0] exp_d, input int exp_lat);
    int cyc;
    bit ok;
    bus.sec_count = val;
    exp_q.push_back(exp_d);
    @(negedge clk);
    check({name, " busy_rise"}, 32'(bus.busy), 32'd1);
    wait_done(name, cyc, ok);
    if (ok) begin
      check({name, " digits"}, 32'(digits_now()), 32'(exp_q.pop_front()));
      check({name, " latency"}, cyc, exp_lat);
      check({name, " busy_fall"}, 32'(bus.busy), 32'd0);
      @(negedge clk);
      check({name, " done_one_cycle"}, 32'(bus.done), 32'd0);
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [CNT_W-1:0] sec;
    logic [15:0]      digs;  // digit3 given as plain BCD
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [15:0] d;
    int lat, cyc;
    bit ok;
    logic [CNT_W-1:0] last_drv;

    vecs[0] = '{12'd125,  16'h0205};
    vecs[1] = '{12'd4095, 16'h6815};
    vecs[2] = '{12'd59,   16'h0059};
    vecs[3] = '{12'd60,   16'h0100};
    vecs[4] = '{12'd65,   16'h0105};
    vecs[5] = '{12'd0,    16'h0000};
    vecs[6] = '{12'd3599, 16'h5959};
    vecs[7] = '{12'd600,  16'h1000};
    vecs[8] = '{12'd9,    16'h0009};
    vecs[9] = '{12'd10,   16'h0010};

    // Reset held with a non-zero input: everything stays at zero.
    rst_n = 1'b0;
    bus.sec_count = 12'd77;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset digits", 32'(digits_now()), 32'h0);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
    end
    bus.sec_count = 12'd125;
    rst_n = 1'b1;

    // Table: fixed digits, latency from the closed form.
    for (int i = 0; i < 10; i++) begin
      int m, s;
      m = int'(vecs[i].sec) / 60;
      s = int'(vecs[i].sec) % 60;
      d = vecs[i].digs;
      d[15:12] = show_d3(d[15:12]);
      run_conv($sformatf("vec%0d", i), vecs[i].sec, d, m + s / 10 + m / 10 + 4);
    end
    last_drv = vecs[9].sec;

    // Change while busy: first result is 68:15, then 00:59 follows.
    bus.sec_count = 12'd4095;
    @(negedge clk);
    check("busy_change busy", 32'(bus.busy), 32'd1);
    repeat (3) @(negedge clk);
    bus.sec_count = 12'd59;
    wait_done("busy_change first", cyc, ok);
    check("busy_change first digits", 32'(digits_now()), 32'({show_d3(4'd6), 12'h815}));
    wait_done("busy_change second", cyc, ok);
    check("busy_change second digits", 32'(digits_now()), 32'({show_d3(4'd0), 12'h059}));
    @(negedge clk);

    // Reset in the middle of DIV60: digits clear at once, no done pulse.
    bus.sec_count = 12'd4095;
    @(negedge clk);
    check("abort busy", 32'(bus.busy), 32'd1);
    repeat (2) @(negedge clk);
    check("abort pre digits", 32'(digits_now()), 32'({show_d3(4'd0), 12'h059}));
    rst_n = 1'b0;
    #1;
    check("abort async digits", 32'(digits_now()), 32'h0);
    check("abort async busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort no done", 32'(bus.done), 32'd0);
    end
    bus.sec_count = 12'd60;
    rst_n = 1'b1;
    ref_model(60, d, lat);
    run_conv("after_abort", 12'd60, d, lat);
    last_drv = 12'd60;

    // Randomized values against the reference model.
    for (int i = 0; i < 20; i++) begin
      logic [CNT_W-1:0] v;
      v = CNT_W'($urandom_range(0, 4095));
      if (v == last_drv) v = v + 12'd1;
      ref_model(int'(v), d, lat);
      run_conv($sformatf("rand%0d(%0d)", i, v), v, d, lat);
      last_drv = v;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
